// File: rtl/line_mirror.sv
// line_mirror: horizontal line mirror / one-line delay using ping-pong line banks.
// Line N is written into one bank while line N-1 is read from the other,
// either reversed (mirror) or in order (straight). Output is 2 cycles behind input.
// Optional status outputs (overflow, line_len) are built when LINE_MIRROR_STATUS_EN
// is defined; the default build omits them.
module line_mirror #(
  parameter  int CH_W     = 8,
  parameter  int CHANNELS = 3,
  parameter  int MAX_H    = 1920,
  localparam int PW       = CH_W * CHANNELS,
  localparam int AW       = $clog2(MAX_H)
) (
  input  logic          pix_1x_clk,
  input  logic          reset_in,
  input  logic          de_in,
  input  logic [PW-1:0] pix_in,
  input  logic          mirror_en,
`ifdef LINE_MIRROR_STATUS_EN
  output logic          overflow,
  output logic [AW:0]   line_len,
`endif
  output logic          de_out,
  output logic [PW-1:0] pix_out
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_H);

  typedef enum logic {BLANK, ACTIVE} state_t;

  state_t        state_q;
  logic [CW-1:0] wr_cnt_q;     // also the read index k of the current line
  logic [CW-1:0] prev_len_q;
  logic          prev_valid_q;
  logic          bank_q;       // bank being written this line
  logic          mode_q;
  logic          armed_q;      // seen de_in low since reset: next high run is a whole line
`ifdef LINE_MIRROR_STATUS_EN
  logic          overflow_q;
`endif

  logic [PW-1:0] bank0 [MAX_H];
  logic [PW-1:0] bank1 [MAX_H];
  logic [PW-1:0] rd_data_q;
  logic [1:0]    de_pipe_q;    // de_in delayed 1 and 2 cycles
  logic          hit1_q;       // stage-1 read returned a real stored pixel
  logic [PW-1:0] pix_out_q;

  logic          line_on;
  logic          mode_eff;
  logic          rd_hit;
  logic          wr_en;
  logic [AW-1:0] rd_addr;

  // Read address for this cycle; the first pixel of a line uses mirror_en directly
  // because mode_q only captures it on that same edge.
  always_comb begin
    line_on  = de_in && ((state_q == ACTIVE) || armed_q);
    mode_eff = (state_q == ACTIVE) ? mode_q : mirror_en;
    rd_hit   = line_on && prev_valid_q && (wr_cnt_q < prev_len_q);
    wr_en    = line_on && (wr_cnt_q != MAX_CNT);
    rd_addr  = '0;
    if (rd_hit)
      rd_addr = AW'(mode_eff ? (prev_len_q - CW'(1) - wr_cnt_q) : wr_cnt_q);
  end

  // Line control FSM: counts pixels, and on de_in falling edge latches the line
  // length and swaps banks.
  always_ff @(posedge pix_1x_clk or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= BLANK;
      wr_cnt_q     <= '0;
      prev_len_q   <= '0;
      prev_valid_q <= 1'b0;
      bank_q       <= 1'b0;
      mode_q       <= 1'b0;
      armed_q      <= 1'b0;
`ifdef LINE_MIRROR_STATUS_EN
      overflow_q   <= 1'b0;
`endif
    end else begin
      armed_q <= armed_q | ~de_in;
      case (state_q)
        BLANK: begin
          if (line_on) begin
            state_q  <= ACTIVE;
            mode_q   <= mirror_en;
            wr_cnt_q <= CW'(1);
          end
        end
        ACTIVE: begin
          if (de_in) begin
            if (wr_cnt_q != MAX_CNT) wr_cnt_q <= wr_cnt_q + CW'(1);
`ifdef LINE_MIRROR_STATUS_EN
            else                     overflow_q <= 1'b1;
`endif
          end else begin
            state_q      <= BLANK;
            prev_len_q   <= wr_cnt_q;
            prev_valid_q <= 1'b1;
            bank_q       <= ~bank_q;
            wr_cnt_q     <= '0;
          end
        end
        default: state_q <= BLANK;
      endcase
    end
  end

  // Line banks (not reset; prev_valid masks stale contents) and registered read
  // from the bank not being written.
  always_ff @(posedge pix_1x_clk) begin
    if (wr_en) begin
      if (bank_q) bank1[wr_cnt_q[AW-1:0]] <= pix_in;
      else        bank0[wr_cnt_q[AW-1:0]] <= pix_in;
    end
    rd_data_q <= bank_q ? bank0[rd_addr] : bank1[rd_addr];
  end

  // Output alignment: de delay line and output register zeroing non-stored slots.
  always_ff @(posedge pix_1x_clk or posedge reset_in) begin
    if (reset_in) begin
      de_pipe_q <= '0;
      hit1_q    <= 1'b0;
      pix_out_q <= '0;
    end else begin
      de_pipe_q <= {de_pipe_q[0], de_in};
      hit1_q    <= rd_hit;
      pix_out_q <= (de_pipe_q[0] && hit1_q) ? rd_data_q : '0;
    end
  end

  assign de_out  = de_pipe_q[1];
  assign pix_out = pix_out_q;
`ifdef LINE_MIRROR_STATUS_EN
  assign overflow = overflow_q;
  assign line_len = prev_len_q;
`endif

endmodule

// File: tb/tb_line_mirror.sv
// Self-checking bench for line_mirror (MAX_H=8). Expected output per cycle is
// pushed to a scoreboard queue as stimulus is driven and popped when the DUT's
// 2-cycle-delayed output for that slot is sampled.
module tb_line_mirror;
  localparam int CH_W = 8, CHANNELS = 3, MAX_H = 8;
  localparam int PW = CH_W * CHANNELS;
  localparam int AW = $clog2(MAX_H);

  typedef struct {
    logic          de;
    logic [PW-1:0] pix;
  } exp_t;

  logic          pix_1x_clk = 1'b0;
  logic          reset_in;
  logic          de_in;
  logic [PW-1:0] pix_in;
  logic          mirror_en;
  logic          de_out;
  logic [PW-1:0] pix_out;
`ifdef LINE_MIRROR_STATUS_EN
  logic          overflow;
  logic [AW:0]   line_len;
`endif

  line_mirror #(.CH_W(CH_W), .CHANNELS(CHANNELS), .MAX_H(MAX_H)) dut (
    .pix_1x_clk (pix_1x_clk),
    .reset_in   (reset_in),
    .de_in      (de_in),
    .pix_in     (pix_in),
    .mirror_en  (mirror_en),
`ifdef LINE_MIRROR_STATUS_EN
    .overflow   (overflow),
    .line_len   (line_len),
`endif
    .de_out     (de_out),
    .pix_out    (pix_out)
  );

  always #5 pix_1x_clk = ~pix_1x_clk;

  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  string cur_test = "none";

  // reference of the previously completed line
  int    m_prev[MAX_H];
  int    m_len   = 0;
  bit    m_valid = 0;

  task automatic sb_restart();
    exp_t z;
    z.de = 1'b0; z.pix = '0;
    sb.delete();
    sb.push_back(z);
  endtask

  // One clock: drive inputs, queue expectation, compare the slot now due at the output.
  task automatic cycle(input logic de, input logic [PW-1:0] px,
                       input logic e_de, input logic [PW-1:0] e_px);
    exp_t e, got;
    de_in = de; pix_in = px;
    e.de = e_de; e.pix = e_px;
    sb.push_back(e);
    @(posedge pix_1x_clk); #1;
    if (sb.size() > 1) begin
      got = sb.pop_front();
      n_chk++;
      if (de_out !== got.de || pix_out !== got.pix) begin
        n_fail++;
        $display("FAIL %s: de_out=%b pix_out=%0d, expected de_out=%b pix_out=%0d",
                 cur_test, de_out, pix_out, got.de, got.pix);
      end
    end
  endtask

  // gap blank cycles, then a line of len pixels base+k; flip toggles mirror_en mid-line.
  task automatic send_line(input int len, input int base, input bit mir,
                           input int gap, input bit flip);
    int ev;
    for (int g = 0; g < gap; g++) cycle(1'b0, '0, 1'b0, '0);
    mirror_en = mir;
    for (int k = 0; k < len; k++) begin
      if (flip && k == 1) mirror_en = ~mir;
      ev = 0;
      if (m_valid && k < m_len) ev = mir ? m_prev[m_len-1-k] : m_prev[k];
      cycle(1'b1, PW'(base + k), 1'b1, PW'(ev));
    end
    m_len = (len > MAX_H) ? MAX_H : len;
    for (int i = 0; i < m_len; i++) m_prev[i] = base + i;
    m_valid = 1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset_in = 1'b1; de_in = 1'b0; pix_in = '0; mirror_en = 1'b0;
    repeat (3) @(posedge pix_1x_clk);
    #1;
    n_chk++;
    if (de_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_de_out: got %b, expected 0", de_out);
    end
    n_chk++;
    if (pix_out !== '0) begin
      n_fail++; $display("FAIL reset_pix_out: got %0d, expected 0", pix_out);
    end
`ifdef LINE_MIRROR_STATUS_EN
    n_chk++;
    if (overflow !== 1'b0 || line_len !== '0) begin
      n_fail++; $display("FAIL reset_status: got ovf=%b len=%0d, expected 0 0", overflow, line_len);
    end
`endif
    reset_in = 1'b0;
    sb_restart();
    m_valid = 0; m_len = 0;
  endtask

  task automatic test_first_then_mirror();
    cur_test = "first_line";
    send_line(8, 0, 1'b1, 2, 1'b0);      // all zeros, de_out high
    cur_test = "mirror";
    send_line(8, 10, 1'b1, 1, 1'b0);     // 7..0
  endtask

  task automatic test_straight();
    cur_test = "straight";
    send_line(8, 20, 1'b0, 1, 1'b0);     // 10..17
  endtask

  task automatic test_short_line();
    cur_test = "short_line";
    send_line(4, 30, 1'b1, 1, 1'b0);     // 27..24
    send_line(6, 40, 1'b1, 1, 1'b0);     // 33..30,0,0
  endtask

  task automatic test_overflow();
    cur_test = "overflow";
    send_line(10, 50, 1'b0, 1, 1'b0);    // 40..45, then zeros
    send_line(8, 60, 1'b1, 1, 1'b0);     // 57..50
`ifdef LINE_MIRROR_STATUS_EN
    n_chk++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_flag: got %b, expected 1", overflow);
    end
`endif
  endtask

  task automatic test_single_pulse();
    cur_test = "single_pulse";
    send_line(1, 70, 1'b1, 1, 1'b0);     // 67
    send_line(3, 80, 1'b1, 1, 1'b0);     // 70,0,0
  endtask

  task automatic test_midline_mode();
    cur_test = "midline_mode";
    send_line(8, 90, 1'b0, 1, 1'b1);     // straight 80..82 despite toggle
    send_line(8, 100, 1'b1, 1, 1'b1);    // mirrored 97..90 despite toggle
  endtask

  task automatic test_reset_midline();
    cur_test = "reset_midline";
    mirror_en = 1'b1;
    cycle(1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 4; k++)
      cycle(1'b1, PW'(110 + k), 1'b1, PW'(m_prev[m_len-1-k]));
    reset_in = 1'b1;
    #1;
    n_chk++;
    if (de_out !== 1'b0 || pix_out !== '0) begin
      n_fail++;
      $display("FAIL reset_midline_outputs: got de_out=%b pix_out=%0d, expected 0 0", de_out, pix_out);
    end
    @(posedge pix_1x_clk); #1;
    reset_in = 1'b0;
    sb_restart();
    m_valid = 0; m_len = 0;
    for (int k = 4; k < 8; k++) cycle(1'b1, PW'(110 + k), 1'b1, '0);
    cur_test = "after_reset_line";
    send_line(8, 120, 1'b1, 1, 1'b0);    // zeros
    cur_test = "after_reset_mirror";
    send_line(8, 130, 1'b1, 1, 1'b0);    // 127..120
    repeat (3) cycle(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_first_then_mirror();
    test_straight();
    test_short_line();
    test_overflow();
    test_single_pulse();
    test_midline_mode();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_mirror.md
LINE_MIRROR -- requirements
Module: line_mirror

Interface
REQ-001 Parameter CH_W, default 8: bits per colour channel.
REQ-002 Parameter CHANNELS, default 3: channels per pixel; pixel width PW = CH_W*CHANNELS, channel 0 in LSBs.
REQ-003 Parameter MAX_H, default 1920: maximum active pixels per line; address width AW = clog2(MAX_H).
REQ-004 pix_1x_clk  input  1  pixel clock; all logic on rising edge.
REQ-005 reset_in  input  1  reset, asynchronous, active-high.
REQ-006 de_in  input  1  active-video qualifier; one contiguous high run per line.
REQ-007 pix_in  input  PW  input pixel, valid when de_in=1.
REQ-008 mirror_en  input  1  1 = horizontal mirror, 0 = straight line delay; sampled on de_in rising edge.
REQ-009 de_out  output  1  de_in delayed exactly 2 cycles.
REQ-010 pix_out  output  PW  output pixel aligned with de_out; 0 when de_out=0.

Function
REQ-011 Two line banks of MAX_H x PW (ping-pong); bank select toggles on every de_in falling edge.
REQ-012 During line N, write bank stores pix_in at wr_cnt (0,1,2,...) while the other bank is read.
REQ-013 On de_in falling edge, final wr_cnt (clamped to MAX_H) is latched as prev_len and prev_valid set to 1.
REQ-014 mirror_en is latched into mode_q on de_in rising edge; mid-line changes are ignored.
REQ-015 Read address at read index k: mode_q=1 -> prev_len-1-k; mode_q=0 -> k.
REQ-016 Latency: cycle 1 registered RAM read, cycle 2 output register; pixel k of line N-1 (mirrored or not) appears on pix_out 2 cycles after pixel k of line N enters.
REQ-017 Output line length follows de_in, not prev_len: for k >= prev_len, pix_out = 0 with de_out=1.
REQ-018 While prev_valid=0 (first line after reset), pix_out = 0 with de_out following de_in.
REQ-019 Pixels beyond MAX_H in a line are not written; wr_cnt saturates at MAX_H; no wrap into address 0.
REQ-020 Single-cycle de_in pulse is a valid line of length 1; bank still toggles.
REQ-021 de_in low for one cycle between lines is sufficient; falling-edge toggle and rising-edge latch in adjacent cycles are both honoured.
REQ-022 Read and write never target the same bank in the same cycle; no read-during-write hazard exists.
REQ-023 Line control is a 2-state FSM: BLANK (de_in=0, counters held at 0) -> ACTIVE on de_in=1; ACTIVE -> BLANK on de_in=0 with bank toggle and prev_len latch.

Reset
REQ-024 reset_in forces de_out=0, pix_out=0, wr_cnt=0, rd_cnt=0, prev_len=0, prev_valid=0, bank select=0, mode_q=0, FSM=BLANK.
REQ-025 Line-bank contents are not reset; prev_valid=0 masks them.
REQ-026 Reset asserted mid-line aborts the line; first line after release is treated as the first line after reset.

Configuration
REQ-027 Macro LINE_MIRROR_STATUS_EN defined: adds outputs overflow (1 bit, sticky, set when a line exceeds MAX_H, cleared only by reset_in) and line_len (AW+1 bits, equals prev_len).
REQ-028 Macro LINE_MIRROR_STATUS_EN undefined: overflow and line_len ports and their logic are absent; all other behaviour identical.

Verification
REQ-029 MAX_H=8, mirror_en=1, lines of 8 pixels 0..7 then 10..17 -> line 2 output 7,6,5,4,3,2,1,0, de_out 2 cycles after de_in.
REQ-030 mirror_en=0, same stimulus -> line 2 output 0..7 unchanged, 2-cycle latency.
REQ-031 First line after reset with any data -> pix_out=0 for all 8 cycles, de_out asserted.
REQ-032 Line of 4 pixels A,B,C,D then line of 6, mirror -> output D,C,B,A,0,0.
REQ-033 Line of 10 pixels with MAX_H=8 -> only first 8 stored; next line mirrors pixel 7..0; overflow=1 when STATUS_EN defined.
REQ-034 reset_in pulsed mid-line 3 -> de_out/pix_out 0 next cycle; line 4 output all zeros; line 5 mirrors line 4.
